// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration sequencer: header layout and FSM states.
package frame_cfg_pkg;

    localparam logic [7:0]  SYNC_BYTE     = 8'hFA;
    localparam int unsigned HDR_FIELD_W   = 8;
    localparam int unsigned HDR_SYNC_LSB  = 24;
    localparam int unsigned HDR_COL_LSB   = 16;
    localparam int unsigned HDR_FRAME_LSB = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        GUARD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder from (column, frame, enable) to the FrameStrobe vector.
module frame_strobe_decoder #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumColumns      = 16,
    parameter int unsigned ColW            = 4,
    parameter int unsigned FrameW          = 5
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [ColW-1:0]                       column,
    input  logic [FrameW-1:0]                     frame,
    input  logic                                  en,
    output logic [MaxFramesPerCol*NumColumns-1:0] strobe
);

    localparam int unsigned NumStrobes = MaxFramesPerCol * NumColumns;
    localparam int unsigned IdxW       = (NumStrobes > 1) ? $clog2(NumStrobes) : 1;

    logic [IdxW-1:0] idx;

    assign idx = IdxW'(column) * IdxW'(MaxFramesPerCol) + IdxW'(frame);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            strobe <= '0;
        end else begin
            strobe <= en ? (NumStrobes'(1) << idx) : '0;
        end
    end

endmodule

// File: rtl/frame_config_sequencer.sv
// Loads one frame (header + NumRows words) onto FrameData, then strobes one FrameStrobe bit.
// Optional macro FRAME_SEQ_COUNT_EN adds a saturating 16-bit FrameCount output.
module frame_config_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned NumRows         = 8,
    parameter int unsigned NumColumns      = 16,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [FrameBitsPerRow-1:0]            WordData,
    input  logic                                  WordValid,
    output logic                                  WordReady,
    input  logic                                  ErrClear,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  Busy,
    output logic                                  Error
`ifdef FRAME_SEQ_COUNT_EN
    ,
    output logic [15:0]                           FrameCount
`endif
);

    localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned StrobeW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam int unsigned ColW    = (NumColumns > 1) ? $clog2(NumColumns) : 1;
    localparam int unsigned FrameW  = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

    seq_state_t         state;
    logic [RowW-1:0]    row_cnt;
    logic [StrobeW-1:0] strobe_cnt;
    logic [ColW-1:0]    col_q;
    logic [FrameW-1:0]  frame_q;

    logic                   transfer;
    logic                   last_row;
    logic                   strobe_en;
    logic [HDR_FIELD_W-1:0] hdr_sync;
    logic [HDR_FIELD_W-1:0] hdr_col;
    logic [HDR_FIELD_W-1:0] hdr_frame;
    logic                   hdr_ok;

    // Ready depends on state only; held low while reset is asserted.
    assign WordReady = !RST && (state == IDLE || state == LOAD);
    assign Busy      = (state != IDLE);
    assign transfer  = WordValid && WordReady;

    assign hdr_sync  = WordData[HDR_SYNC_LSB  +: HDR_FIELD_W];
    assign hdr_col   = WordData[HDR_COL_LSB   +: HDR_FIELD_W];
    assign hdr_frame = WordData[HDR_FRAME_LSB +: HDR_FIELD_W];
    assign hdr_ok    = (hdr_sync == SYNC_BYTE) &&
                       (hdr_col < HDR_FIELD_W'(NumColumns)) &&
                       (hdr_frame < HDR_FIELD_W'(MaxFramesPerCol));

    assign last_row  = (row_cnt == RowW'(NumRows - 1));

    // Strobe register is loaded on the edge that completes the frame and held for StrobeCycles.
    assign strobe_en = ((state == LOAD) && transfer && last_row) ||
                       ((state == STROBE) && (strobe_cnt != StrobeW'(StrobeCycles - 1)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            row_cnt    <= '0;
            strobe_cnt <= '0;
            col_q      <= '0;
            frame_q    <= '0;
            FrameData  <= '0;
            Error      <= 1'b0;
        end else begin
            if (ErrClear) begin
                Error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (transfer) begin
                        if (hdr_ok) begin
                            col_q   <= ColW'(hdr_col);
                            frame_q <= FrameW'(hdr_frame);
                            row_cnt <= '0;
                            state   <= LOAD;
                        end else begin
                            Error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        for (int r = 0; r < int'(NumRows); r++) begin
                            if (row_cnt == RowW'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= WordData;
                            end
                        end
                        if (last_row) begin
                            row_cnt    <= '0;
                            strobe_cnt <= '0;
                            state      <= STROBE;
                        end else begin
                            row_cnt <= row_cnt + RowW'(1);
                        end
                    end
                end
                STROBE: begin
                    if (strobe_cnt == StrobeW'(StrobeCycles - 1)) begin
                        strobe_cnt <= '0;
                        state      <= GUARD;
                    end else begin
                        strobe_cnt <= strobe_cnt + StrobeW'(1);
                    end
                end
                GUARD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_SEQ_COUNT_EN
    logic [15:0] count_q;

    // Counts frames as they enter STROBE; saturates and ignores ErrClear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else if ((state == LOAD) && transfer && last_row && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign FrameCount = count_q;
`endif

    frame_strobe_decoder #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .NumColumns      (NumColumns),
        .ColW            (ColW),
        .FrameW          (FrameW)
    ) u_strobe_decoder (
        .CLK    (CLK),
        .RST    (RST),
        .column (col_q),
        .frame  (frame_q),
        .en     (strobe_en),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench for frame_config_sequencer with randomized frames and a frame-level model.
module tb_frame_config_sequencer;

    localparam int unsigned FB = 32;
    localparam int unsigned MF = 20;
    localparam int unsigned NR = 8;
    localparam int unsigned NC = 16;
    localparam int unsigned SC = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [FB-1:0]     WordData;
    logic              WordValid;
    logic              WordReady;
    logic              ErrClear;
    logic [FB*NR-1:0]  FrameData;
    logic [MF*NC-1:0]  FrameStrobe;
    logic              Busy;
    logic              Error;
`ifdef FRAME_SEQ_COUNT_EN
    logic [15:0]       FrameCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [FB-1:0] exp_rows [NR];
    logic          exp_err;
    int            exp_count;

    always #5 CLK = ~CLK;

    frame_config_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .WordData    (WordData),
        .WordValid   (WordValid),
        .WordReady   (WordReady),
        .ErrClear    (ErrClear),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Busy        (Busy),
        .Error       (Error)
`ifdef FRAME_SEQ_COUNT_EN
        ,
        .FrameCount  (FrameCount)
`endif
    );

    function automatic logic [FB*NR-1:0] exp_frame();
        logic [FB*NR-1:0] v;
        for (int r = 0; r < int'(NR); r++) v[r*FB +: FB] = exp_rows[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < int'(NR); r++) exp_rows[r] = '0;
        exp_err   = 1'b0;
        exp_count = 0;
    endtask

    // Presents one word and waits (bounded) for it to transfer; returns #1 after the edge.
    task automatic send_word(input logic [FB-1:0] w);
        int n = 0;
        WordData  = w;
        WordValid = 1'b1;
        while (!WordReady && n < 200) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL send_word_timeout: WordReady=%0b for %0d cycles, required 1", WordReady, n);
        end
        @(posedge CLK);
        #1;
        WordValid = 1'b0;
    endtask

    task automatic do_frame(input int col, input int frm, input bit rand_rows, input bit gaps);
        logic [FB-1:0]    w;
        logic [MF*NC-1:0] one_hot;
        logic [MF*NC-1:0] exp_stb;
        send_word({8'hFA, 8'(col), 8'(frm), 8'h00});
        n_checks++;
        if (Busy !== 1'b1 || FrameStrobe !== '0) begin
            n_fail++;
            $display("FAIL after_header: Busy=%0b strobe=%h, required Busy=1 strobe=0", Busy, FrameStrobe);
        end
        for (int k = 0; k < int'(NR); k++) begin
            w = rand_rows ? FB'($urandom) : FB'(32'h1000_0000 + k);
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge CLK);
                    #1;
                end
            end
            send_word(w);
            exp_rows[k] = w;
        end
        one_hot = '0;
        one_hot[col*MF + frm] = 1'b1;
        if (exp_count < 65535) exp_count++;
        for (int c = 0; c <= int'(SC); c++) begin
            exp_stb = (c < int'(SC)) ? one_hot : '0;
            n_checks++;
            if (FrameStrobe !== exp_stb || WordReady !== 1'b0 || Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL strobe_window c=%0d col=%0d frm=%0d: strobe=%h ready=%0b busy=%0b, required strobe=%h ready=0 busy=1",
                         c, col, frm, FrameStrobe, WordReady, Busy, exp_stb);
            end
            n_checks++;
            if (FrameData !== exp_frame()) begin
                n_fail++;
                $display("FAIL frame_data c=%0d: got %h, required %h", c, FrameData, exp_frame());
            end
            @(posedge CLK);
            #1;
        end
        n_checks++;
        if (FrameStrobe !== '0 || WordReady !== 1'b1 || Busy !== 1'b0 || Error !== exp_err) begin
            n_fail++;
            $display("FAIL after_guard: strobe=%h ready=%0b busy=%0b err=%0b, required strobe=0 ready=1 busy=0 err=%0b",
                     FrameStrobe, WordReady, Busy, Error, exp_err);
        end
`ifdef FRAME_SEQ_COUNT_EN
        n_checks++;
        if (FrameCount !== 16'(exp_count)) begin
            n_fail++;
            $display("FAIL frame_count: got %0d, required %0d", FrameCount, exp_count);
        end
`endif
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        WordValid = 1'b0;
        WordData  = '0;
        ErrClear  = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (WordReady !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %0b, required 0", WordReady);
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if (FrameData !== '0 || FrameStrobe !== '0 || Busy !== 1'b0 || Error !== 1'b0 || WordReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: fd=%h stb=%h busy=%0b err=%0b ready=%0b, required 0/0/0/0/1",
                     FrameData, FrameStrobe, Busy, Error, WordReady);
        end
`ifdef FRAME_SEQ_COUNT_EN
        n_checks++;
        if (FrameCount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", FrameCount);
        end
`endif
    endtask

    task automatic test_basic_load();
        do_frame(3, 5, 1'b0, 1'b0);
    endtask

    task automatic test_bad_headers();
        logic [FB-1:0] bad [3];
        bad[0] = 32'hFB00_0000;
        bad[1] = 32'hFA10_0000;
        bad[2] = 32'hFA00_1400;
        for (int i = 0; i < 3; i++) begin
            send_word(bad[i]);
            exp_err = 1'b1;
            n_checks++;
            if (Error !== 1'b1 || Busy !== 1'b0 || FrameStrobe !== '0 || FrameData !== exp_frame()) begin
                n_fail++;
                $display("FAIL bad_header_%0d: err=%0b busy=%0b stb=%h, required err=1 busy=0 stb=0 data unchanged",
                         i, Error, Busy, FrameStrobe);
            end
        end
        // A valid frame still loads while Error is set, and Error stays set.
        do_frame(15, 19, 1'b1, 1'b0);
        ErrClear = 1'b1;
        send_word(32'h12FA_0000);
        ErrClear = 1'b0;
        n_checks++;
        if (Error !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_set: err=%0b, required 1", Error);
        end
        ErrClear = 1'b1;
        @(posedge CLK);
        #1;
        ErrClear = 1'b0;
        exp_err  = 1'b0;
        n_checks++;
        if (Error !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%0b, required 0", Error);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) begin
            do_frame(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, MF - 1)), 1'b1, 1'b1);
        end
    endtask

    task automatic test_mid_reset();
        send_word(32'hFA02_0400);
        for (int k = 0; k < 4; k++) send_word(FB'($urandom));
        RST = 1'b1;
        #1;
        n_checks++;
        if (FrameData !== '0 || FrameStrobe !== '0 || Busy !== 1'b0 || WordReady !== 1'b0 || Error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: fd=%h stb=%h busy=%0b ready=%0b err=%0b, required all 0",
                     FrameData, FrameStrobe, Busy, WordReady, Error);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (FrameStrobe !== '0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_strobe_after_reset: stb=%h busy=%0b, required 0/0", FrameStrobe, Busy);
        end
        do_frame(2, 4, 1'b1, 1'b0);
        // Reset in the first strobe cycle drops the strobe at once.
        send_word(32'hFA09_0B00);
        for (int k = 0; k < int'(NR); k++) send_word(FB'($urandom));
        RST = 1'b1;
        #1;
        n_checks++;
        if (FrameStrobe !== '0 || FrameData !== '0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_strobe: stb=%h fd=%h busy=%0b, required 0/0/0", FrameStrobe, FrameData, Busy);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        do_frame(0, 0, 1'b1, 1'b0);
        do_frame(0, 1, 1'b1, 1'b0);
        do_frame(0, 19, 1'b1, 1'b0);
`ifdef FRAME_SEQ_COUNT_EN
        n_checks++;
        if (FrameCount !== 16'd3) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d, required 3", FrameCount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_headers();
        test_gapped();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
